// File: rtl/scr1_wfi_sleep_ctrl.sv
// WFI sleep sequencer: turns a retiring WFI into sleep_pipe / wake_pipe
// requests for the core clock controller, and counts gated cycles.
// Runs on the always-on core clock. Every output is registered.
module scr1_wfi_sleep_ctrl #(
  parameter int DRAIN_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sleep_en,
  input  logic             wfi_req,
  input  logic             pipe_idle,
  input  logic             irq_pending,
  input  logic             dbg_halt_req,
  input  logic             dbg_mode,
  input  logic             clk_pipe_en,
  input  logic             sleep_cnt_clr,
  output logic             fetch_stall,
  output logic             sleep_pipe,
  output logic             wake_pipe,
  output logic             wfi_done,
  output logic             drain_abort,
  output logic [CNT_W-1:0] sleep_cycles
);

  // Drain counter only needs to reach DRAIN_TIMEOUT-1; a 0 timeout disables it.
  localparam int DCNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST =
    DCNT_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_ON = (DRAIN_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DCNT_W-1:0] drain_cnt;

  logic wake_evt;
  logic nop_wfi;
  logic drain_expired;

  logic fetch_stall_d;
  logic sleep_pipe_d;
  logic wake_pipe_d;
  logic wfi_done_d;
  logic drain_abort_d;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wake_evt      = irq_pending | dbg_halt_req;
  // A WFI that cannot or need not sleep completes immediately as a NOP.
  assign nop_wfi       = ~sleep_en | dbg_mode | wake_evt;
  assign drain_expired = TIMEOUT_ON && (drain_cnt == DRAIN_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next-state logic; wake beats idle beats timeout while draining.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (wfi_req && !nop_wfi) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (wake_evt)           state_next = ST_WAKE;
        else if (pipe_idle)     state_next = ST_SLEEP;
        else if (drain_expired) state_next = ST_WAKE;
      end
      ST_SLEEP: if (wake_evt) state_next = ST_WAKE;
      ST_WAKE:  if (clk_pipe_en) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    fetch_stall_d = (state_next != ST_RUN);
    sleep_pipe_d  = (state_next == ST_SLEEP);
    wake_pipe_d   = (state_next == ST_WAKE);
    wfi_done_d    = ((state == ST_RUN) && wfi_req && nop_wfi) ||
                    ((state == ST_WAKE) && clk_pipe_en);
    drain_abort_d = (state == ST_DRAIN) && !wake_evt && !pipe_idle && drain_expired;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_stall <= 1'b0;
      sleep_pipe  <= 1'b0;
      wake_pipe   <= 1'b0;
      wfi_done    <= 1'b0;
      drain_abort <= 1'b0;
    end else begin
      fetch_stall <= fetch_stall_d;
      sleep_pipe  <= sleep_pipe_d;
      wake_pipe   <= wake_pipe_d;
      wfi_done    <= wfi_done_d;
      drain_abort <= drain_abort_d;
    end
  end

  // Drain counter: held at zero outside DRAIN so each drain starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_DRAIN) drain_cnt <= '0;
    else                             drain_cnt <= drain_cnt + DCNT_W'(1);
  end

  // Sleep-cycle counter: counts gated cycles in SLEEP, clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 sleep_cycles <= '0;
    else if (sleep_cnt_clr)                     sleep_cycles <= '0;
    else if (state == ST_SLEEP && !clk_pipe_en) sleep_cycles <= sat_inc(sleep_cycles);
  end

endmodule
